// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state encoding and host-link message codes
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Message type carried in byte bits [1:0], decoded downstream.
  localparam logic [1:0] MSG_FEEDBACK = 2'b01;
  localparam logic [1:0] MSG_SCRIPT   = 2'b10;

endpackage

// File: rtl/uart_byte_receiver_if.sv
// rtl/uart_byte_receiver_if.sv - received-byte handshake between receiver and command decoder
interface uart_byte_receiver_if;
  import uart_pkg::*;

  logic                      data_valid;
  logic [UART_DATA_BITS-1:0] data_receive;
  logic                      frame_error;
  logic                      busy;

  modport master (output data_valid, data_receive, frame_error, busy);
  modport slave  (input  data_valid, data_receive, frame_error, busy);

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer for an idle-high UART input, resets to 1
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// rtl/uart_byte_receiver.sv - 8N1 UART byte receiver (8E1 when UART_PARITY_EN is defined)
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  input  logic                  rx,
  uart_byte_receiver_if.master  link
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF    = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] data_r;
  logic                      valid_r;
  logic                      err_r;
  logic                      busy_r;
  logic                      rx_s;
  logic                      parity_ok;

  uart_rx_sync u_sync (
    .clk   (uart_clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_PARITY_EN
  logic parity_bit;
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign parity_ok = ~^{shreg, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_WAIT_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        ST_WAIT_IDLE: begin
          busy_r <= ~rx_s;
          if (rx_s) state <= ST_IDLE;
        end
        ST_IDLE: begin
          busy_r <= ~rx_s;
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_BIT_END) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (cnt == CNT_BIT_END) begin
            cnt        <= '0;
            parity_bit <= rx_s;
            state      <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == CNT_BIT_END) begin
            cnt <= '0;
            // A low stop bit usually means a break; wait for the line to recover.
            if (!rx_s) begin
              err_r <= 1'b1;
              state <= ST_WAIT_IDLE;
            end else if (!parity_ok) begin
              err_r  <= 1'b1;
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end else begin
              data_r  <= shreg;
              valid_r <= 1'b1;
              state   <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

  assign link.data_valid   = valid_r;
  assign link.data_receive = data_r;
  assign link.frame_error  = err_r;
  assign link.busy         = busy_r;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb/tb_uart_byte_receiver.sv - scoreboard bench for uart_byte_receiver with random frames
module tb_uart_byte_receiver;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  uart_byte_receiver_if link ();

  uart_byte_receiver #(.CLKS_PER_BIT(N)) dut (
    .uart_clk (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .link     (link)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (N) @(posedge clk);
      #1;
    end
  endtask

  // Reference: a frame yields its byte when stop is high and parity even, else an error,
  // reported at the stop-bit mid-sample: 3 edges of sync/detect, then H, then one N per bit.
  task automatic send_raw(input logic [7:0] d, input logic par, input logic stop);
    exp_t e;
    logic ok;
    logic [10:0] bits;
`ifdef UART_PARITY_EN
    ok   = stop && ((^d ^ par) == 1'b0);
    bits = {stop, par, d, 1'b0};
`else
    ok   = stop && (par == ^d);
    bits = {1'b0, stop, d, 1'b0};
`endif
    e.is_err = !ok;
    e.data   = d;
    e.cyc    = cyc + 3 + H + (NBITS - 1) * N;
    sb.push_back(e);
    if (ok) last_good = d;
    send_bits(bits, NBITS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_raw(d, ^d, stop);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 * N && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", sb.size(), 0);
    check("data_hold", link.data_receive, last_good);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, link.data_valid, 0);
    check({tag, "_data"},  link.data_receive, 0);
    check({tag, "_ferr"},  link.frame_error, 0);
    check({tag, "_busy"},  link.busy, 0);
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (link.data_valid && link.frame_error)
          check("valid_ferr_exclusive", 1, 0);
        if (link.data_valid || link.frame_error) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_kind", link.frame_error, e.is_err);
            if (!e.is_err) check("pulse_data", link.data_receive, e.data);
            check("pulse_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(4);

    send_frame(8'hA5, 1'b1);
    idle(N);
    wait_drain();

    send_frame(8'h3D, 1'b1);
    send_frame(8'hC2, 1'b1);
    idle(N);
    wait_drain();

    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(2 * N);
    check("glitch_busy", link.busy, 0);
    check("glitch_queue", sb.size(), 0);
    check("glitch_data", link.data_receive, last_good);

    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("break_busy", link.busy, 1);
    check("break_queue", sb.size(), 0);
    idle(2 * N);
    check("break_recover_busy", link.busy, 0);
    send_frame(8'h01, 1'b1);
    idle(N);
    wait_drain();

    send_bits({7'h00, 4'b0000}, 5);
    rx = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    send_frame(8'hFF, 1'b1);
    idle(N);
    wait_drain();

`ifdef UART_PARITY_EN
    send_raw(8'h07, 1'b0, 1'b1);
    idle(N);
    wait_drain();
    send_raw(8'h07, 1'b1, 1'b1);
    idle(N);
    wait_drain();
`endif

    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       bad;
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
`ifdef UART_PARITY_EN
      if ($urandom_range(0, 4) == 0) send_raw(d, ~^d, !bad);
      else send_frame(d, !bad);
`else
      send_frame(d, !bad);
`endif
      if (bad) idle(2 * N + $urandom_range(0, N));
      else idle($urandom_range(0, 2 * N));
    end
    idle(N);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
